// File: rtl/counter_driver_pkg.sv
// Shared types and default constants for the counter stimulus/check stage.
package counter_driver_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_SEED        = 71;
  localparam int DEF_IDLE_INIT   = 871;
  localparam int DEF_MAX_ITER    = 200;
  localparam int DEF_PERIOD_LOG2 = 5;

  // err_cnt saturation point
  localparam int ERR_MAX = 255;

endpackage

// File: rtl/counter_driver_checker.sv
// Reference model of the loadable counter plus sticky mismatch / error counter.
module count_checker
  import counter_driver_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] init,
  input  logic [WIDTH-1:0] count,
  input  logic             check_en,
  input  logic             clear,
  output logic             mismatch,
  output logic [7:0]       err_cnt
);

  logic [WIDTH-1:0] exp_q, exp_d;
  logic             exp_valid_q, exp_valid_d;
  logic             mismatch_q, mismatch_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  // Model tracks the counter; compare only once a load has defined its value.
  always_comb begin
    exp_d       = exp_q;
    exp_valid_d = exp_valid_q;
    mismatch_d  = mismatch_q;
    err_cnt_d   = err_cnt_q;
    if (clear) begin
      exp_valid_d = 1'b0;
      mismatch_d  = 1'b0;
      err_cnt_d   = 8'd0;
    end else if (check_en) begin
      if (exp_valid_q && (count != exp_q)) begin
        mismatch_d = 1'b1;
        if (err_cnt_q != 8'(ERR_MAX)) err_cnt_d = err_cnt_q + 8'd1;
      end
      if (ld) begin
        exp_d       = init;
        exp_valid_d = 1'b1;
      end else begin
        exp_d = exp_q + {{(WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  // Model and check state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_q       <= '0;
      exp_valid_q <= 1'b0;
      mismatch_q  <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      exp_q       <= exp_d;
      exp_valid_q <= exp_valid_d;
      mismatch_q  <= mismatch_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign mismatch = mismatch_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: rtl/counter_driver.sv
// Drives ld/init into the loadable counter on a fixed schedule and checks count.
module counter_driver
  import counter_driver_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int PERIOD_LOG2 = DEF_PERIOD_LOG2,
  parameter int SEED        = DEF_SEED,
  parameter int IDLE_INIT   = DEF_IDLE_INIT,
  parameter int MAX_ITER    = DEF_MAX_ITER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ld,
  output logic [WIDTH-1:0] init,
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] iter,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [7:0]       err_cnt
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] iter_q, iter_d;
  logic [WIDTH-1:0] init_q, init_d;
  logic             ld_q, ld_d;
  logic             clear;

  // Next state, iteration index and scrambled reload value.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    init_d  = init_q;
    ld_d    = 1'b0;
    clear   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          iter_d  = '0;
          init_d  = WIDTH'(SEED);
          clear   = 1'b1;
        end
      end
      RUN: begin
        // End of run beats a load boundary on the same edge.
        if (iter_q == WIDTH'(MAX_ITER)) begin
          state_d = DONE;
        end else if (iter_q[PERIOD_LOG2-1:0] == '0) begin
          ld_d   = 1'b1;
          init_d = (init_q << 3) ^ (iter_q >> 2);
          iter_d = iter_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          init_d = WIDTH'(IDLE_INIT);
          iter_d = iter_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and stimulus registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      iter_q  <= '0;
      init_q  <= '0;
      ld_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      init_q  <= init_d;
      ld_q    <= ld_d;
    end
  end

  count_checker #(.WIDTH(WIDTH)) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld       (ld_q),
    .init     (init_q),
    .count    (count),
    .check_en (state_q != IDLE),
    .clear    (clear),
    .mismatch (mismatch),
    .err_cnt  (err_cnt)
  );

  assign ld   = ld_q;
  assign init = init_q;
  assign iter = iter_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_counter_driver.sv
// Scoreboard bench: behavioural counter with fault injection around counter_driver.
module tb_counter_driver;

  logic        clk = 1'b0;
  logic        rst_n, start, fault;
  logic        ld, busy, done, mismatch;
  logic [15:0] init, count, iter;
  logic [7:0]  err_cnt;

  typedef struct packed {
    logic        ld;
    logic [15:0] init;
    logic [15:0] iter;
    logic        busy;
    logic        done;
    logic        mis;
    logic [7:0]  err;
  } obs_t;

  obs_t sb_q[$];
  int   checks = 0, failures = 0;
  int   j = -1;           // edges since start, -1 when idle after reset
  int   m_err = 0;
  bit   m_mis = 1'b0;
  int   pulses = 0;

  always #5 clk = ~clk;

  // Loadable counter stand-in; power-up value deliberately arbitrary.
  logic [15:0] cnt_q = 16'hbeef;
  always @(posedge clk) cnt_q <= ld ? init : cnt_q + 16'd1;
  assign count = cnt_q + {15'd0, fault};

  counter_driver dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ld(ld), .init(init),
    .count(count), .iter(iter), .busy(busy), .done(done),
    .mismatch(mismatch), .err_cnt(err_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] ld_val(input int k);
    logic [15:0] prev, it;
    prev = (k == 0) ? 16'd71 : 16'd871;
    it   = 16'(32 * k);
    return (prev << 3) ^ (it >> 2);
  endfunction

  function automatic obs_t expect_at(input int jj, input int er, input bit mi);
    obs_t e;
    e = '0;
    if (jj == 0) begin
      e.init = 16'd71;
      e.busy = 1'b1;
    end else if (jj >= 1 && jj <= 200) begin
      e.iter = 16'(jj);
      e.busy = 1'b1;
      if ((jj - 1) % 32 == 0) begin
        e.ld   = 1'b1;
        e.init = ld_val((jj - 1) / 32);
      end else begin
        e.init = 16'd871;
      end
    end else if (jj > 200) begin
      e.iter = 16'd200;
      e.init = 16'd871;
      e.done = 1'b1;
    end
    if (jj >= 0) begin
      e.mis = mi;
      e.err = 8'(er);
    end
    return e;
  endfunction

  // Drive one edge, push what the outputs must be after it, then pop and compare.
  task automatic step(input bit st, input bit rn, input bit flt);
    obs_t o, e;
    start = st; rst_n = rn; fault = flt;
    if (!rn) begin
      j = -1; m_err = 0; m_mis = 1'b0;
    end else if (st && (j < 0 || j > 200)) begin
      j = 0; m_err = 0; m_mis = 1'b0;
    end else if (j >= 0) begin
      j++;
      if (flt && j >= 3) begin
        m_mis = 1'b1;
        if (m_err != 255) m_err++;
      end
    end
    sb_q.push_back(expect_at(j, m_err, m_mis));
    @(posedge clk);
    @(negedge clk);
    o = '{ld, init, iter, busy, done, mismatch, err_cnt};
    e = sb_q.pop_front();
    chk($sformatf("cyc_j%0d", j), 64'(o), 64'(e));
    if (o.ld) pulses++;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; fault = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);

    // clean run; start mid-run must be ignored
    pulses = 0;
    step(1, 1, 0);
    for (int i = 1; i <= 210; i++) step(i == 100, 1, 0);
    chk("ld_pulses_run1", 64'(pulses), 64'd7);
    chk("mismatch_clean", 64'(mismatch), 64'd0);

    // restart from DONE, three corrupted samples after the first load
    pulses = 0;
    step(1, 1, 0);
    for (int i = 1; i <= 230; i++) step(0, 1, (i >= 3 && i <= 5));
    chk("ld_pulses_run2", 64'(pulses), 64'd7);
    chk("err_three", 64'(err_cnt), 64'd3);

    // restart clears, then long corruption saturates
    step(1, 1, 0);
    chk("err_cleared", 64'(err_cnt), 64'd0);
    for (int i = 2; i <= 310; i++) step(0, 1, (i >= 3 && i <= 302));
    chk("err_sat", 64'(err_cnt), 64'd255);

    // reset mid-run at iter 50, asserted together with start
    step(1, 1, 0);
    for (int i = 1; i <= 50; i++) step(0, 1, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    pulses = 0;
    step(1, 1, 0);
    for (int i = 1; i <= 210; i++) step(0, 1, 0);
    chk("ld_pulses_rerun", 64'(pulses), 64'd7);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_driver.md
Name: counter_driver

Overview:
- Stimulus-and-check stage wrapped around the 16-bit loadable counter in the yosys tiny integration suite.
- Upstream role: generates the counter's `ld` and `init` inputs on a fixed schedule with a scrambled reload value.
- Downstream role: consumes the counter's `count` output and compares it with an internal reference model.
- Gives the integration test a self-checking, synthesizable top-level partner in place of a `$display`-based bench.

Parameters:
- WIDTH, 16: data width of `init`, `count` and `iter`.
- PERIOD_LOG2, 5: a reload occurs when `iter[PERIOD_LOG2-1:0] == 0`, i.e. every 32 iterations.
- SEED, 71: `init` register value on entering RUN.
- IDLE_INIT, 871: value driven on `init` in non-load cycles.
- MAX_ITER, 200: iteration at which the run ends.

Ports:
- clk       in   1      rising-edge clock
- rst_n     in   1      reset, synchronous, active-low
- start     in   1      begin a run; sampled in IDLE and DONE only
- ld        out  1      load strobe to the counter
- init      out  WIDTH  load value to the counter
- count     in   WIDTH  counter output
- iter      out  WIDTH  current iteration index
- busy      out  1      high while in RUN
- done      out  1      high while in DONE
- mismatch  out  1      sticky flag: count differed from the model
- err_cnt   out  8      number of mismatching cycles, saturates at 255

Behaviour:
- One clock, `clk`. Reset is synchronous, active-low on `rst_n`. All outputs are registered.
- Reset, applied on any edge with `rst_n = 0`, including mid-run:
  - state goes to IDLE.
  - `ld = 0`, `init = 0`, `iter = 0`, `busy = 0`, `done = 0`, `mismatch = 0`, `err_cnt = 0`.
  - model `exp = 0`, `exp_valid = 0`.
- IDLE:
  - `start = 1` moves to RUN.
  - At that edge: `iter <= 0`, `init <= SEED`, `ld <= 0`, `exp_valid <= 0`, `mismatch <= 0`, `err_cnt <= 0`.
- RUN, each edge:
  - If `iter == MAX_ITER`: go to DONE, `ld <= 0`, `iter` holds, `init` holds. This takes priority over the load rule.
  - Else if `iter[PERIOD_LOG2-1:0] == 0`: `ld <= 1`, `init <= ((init << 3) ^ (iter >> 2))`, truncated to WIDTH. Both operands use current register values. `iter <= iter + 1`.
  - Else: `ld <= 0`, `init <= IDLE_INIT`, `iter <= iter + 1`.
  - `start` is ignored.
- DONE:
  - Outputs hold; `ld = 0`.
  - `start = 1` restarts exactly as from IDLE.
- Counter timing: the counter samples `ld`/`init` on the same edge they are visible, so `count` reflects a load one cycle after `ld` is high.
- Reference model, updated every edge in RUN and DONE:
  - If `ld` is high: `exp <= init`, `exp_valid <= 1`.
  - Else: `exp <= exp + 1`, mod 2^WIDTH, with natural wrap-around.
- Check:
  - On every edge with `exp_valid = 1` and `count != exp`: `mismatch <= 1` and `err_cnt <= err_cnt + 1`, saturating at 255.
  - No check before the first load, because the counter's power-up value is not reset.
- Simultaneous events:
  - The done transition and a load boundary on the same edge resolve to done; no load is issued.
  - A reset on the same edge as `start`: reset wins.
- Load pulses per run: 7, at `iter` = 0, 32, 64, 96, 128, 160, 192.
- `busy` and `done` are decoded from the registered state.

Decomposition:
- Package `counter_driver_pkg` holds:
  - state enum `{IDLE, RUN, DONE}`.
  - default constants SEED, IDLE_INIT, MAX_ITER, PERIOD_LOG2.
  - `ERR_MAX = 255`.
- One sub-module, `count_checker`: holds `exp`/`exp_valid`/`mismatch`/`err_cnt` and takes `ld`, `init`, `count`, `check_en` and a clear input. The top holds the FSM, `iter` and the `init` scrambler.

Test Plan:
- Reset, then one cycle of `start`: first RUN edge gives `ld = 1`, `init = 568` (71<<3); next cycle `ld = 0`, `init = 871`; counter `count` reads 568, 569, 570.
- Run to `iter = 32`: `ld = 1`, `init = 6960` ((871<<3)^8); two cycles later `count = 6960`; exactly 7 `ld` pulses per run; `done = 1` and `busy = 0` once `iter = 200`; `mismatch = 0`.
- Fault injection, force `count` +1 on 3 cycles after the first load: `mismatch = 1`, `err_cnt = 3`; sticky until the next `start` or reset.
- Force `count` wrong for 300 cycles: `err_cnt` saturates at 255.
- Drop `rst_n` at `iter = 50` for one edge: all outputs reach reset values on that edge; state is IDLE; `start` then re-runs cleanly from SEED.
- In DONE, pulse `start`: new run begins with `iter = 0`, `init` scrambled from 71 again, `err_cnt = 0`.
